mul_seq: RTL and testbench
==========================

# mul_seq

Multi-cycle 32×32→64 multiplier sequencer for the MIPS datapath, serving `mult`/`multu`. It drives one shared 32-bit `adder` instance with a shift-and-add schedule, one add per cycle, and accumulates the product into HI/LO registers. The control unit starts an operation with a one-cycle pulse and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request pulse; sampled only in IDLE or DONE.
- `sgn` input 1: 1 = signed (`mult`), 0 = unsigned (`multu`); sampled with `start`.
- `a` input 32: multiplicand; sampled with `start`.
- `b` input 32: multiplier; sampled with `start`.
- `busy` output 1: high in CALC and FIX.
- `done` output 1: high exactly one cycle, in DONE.
- `hi` output 32: upper product word.
- `lo` output 32: lower product word.

## Operation
- States:
  - IDLE: reset state.
  - CALC: 32 add/shift steps.
  - FIX: single negate cycle, signed negative results only.
  - DONE: one cycle.
- Accept: `start`=1 in IDLE or DONE.
  - mcand ← |a|, hi ← 0, lo ← |b|, count ← 0.
  - neg ← `sgn` & (a[31] ^ b[31]).
  - |x| = x when `sgn`=0 or x[31]=0; otherwise ~x+1, taken modulo 2^32, so 0x80000000 stays 0x80000000 and is treated as unsigned 2^31.
  - Next state is CALC.
- CALC step:
  - Adder inputs: hi and (lo[0] ? mcand : 0). Sum is `s`.
  - carry c = (s < hi), unsigned compare, because the adder has no carry-out.
  - {hi, lo} ← {c, s, lo[31:1]}.
  - count increments by 1.
  - After the step with count = 31: go to FIX if neg, else DONE.
- FIX: {hi, lo} ← ~{hi, lo} + 1 (64-bit two's complement), then DONE.
- DONE: `done`=1, `busy`=0.
  - With `start`=1: accept a new operation and go to CALC.
  - Otherwise go to IDLE.
- `start` in CALC or FIX is ignored; the operation in flight is unaffected.
- `hi`/`lo` hold the last result from DONE until the next accept. During CALC/FIX they hold intermediate values and must not be consumed.
- Reset (async, any state, including mid-operation):
  - state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0, mcand=0, neg=0.
  - The partial result is discarded.

## Timing
- `start` sampled high at edge E0:
  - `busy`=1 for the next 32 cycles (CALC), plus 1 cycle if FIX.
  - `done`=1 in cycle 33 after E0 when unsigned or non-negative, cycle 34 when negative.
- Latency from start edge to `done`: 33 or 34 cycles. Throughput: one operation per 33/34 cycles with back-to-back `start` in DONE.
- `busy` and `done` are never high together. `busy` drops in the same cycle `done` rises.
- The adder path is combinational within one cycle: hi → adder → carry compare → hi register.
- `done` is registered (decoded from state), with no combinational path from `start`.

## Structure
- Shared package `mul_pkg`:
  - state encodings IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3;
  - `MUL_STEPS`=32 and counter width 5.
- One sub-module: the existing 32-bit `adder` (data1, data2 → result), instantiated once for the CALC step.
- The abs/negate logic and the 64-bit FIX negate are local logic. They do not use the shared adder.
- The FSM, counter and HI/LO registers stay in `mul_seq`. No further sub-modules.

## Test plan
- Unsigned 6×7: `sgn`=0, a=6, b=7 → `done` 33 cycles after start; hi=0x00000000, lo=0x0000002A; `busy` high exactly 32 cycles.
- Carry path: `sgn`=0, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed negative: `sgn`=1, a=0xFFFFFFFD (−3), b=5 → FIX taken, `done` at 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed corner: `sgn`=1, a=b=0x80000000 → neg=0, `done` at 33; hi=0x40000000, lo=0x00000000.
- Ignore and back-to-back:
  - `start` pulsed at CALC cycle 5 with different operands → first result unchanged.
  - `start` held in the DONE cycle with a=2, b=3 → second run begins immediately; hi=0, lo=6 exactly 33 cycles later.
- Reset mid-operation: assert `rst` at CALC cycle 10 → `busy`, `done`, `hi`, `lo` all 0 without waiting for a clock edge. After release, a=9, b=9, `sgn`=0 gives lo=0x51 at 33 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: state encoding and step counter sizing.
package mul_pkg;

    localparam int unsigned MUL_STEPS = 32;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/adder.sv
// Shared datapath adder: plain modulo-2^WIDTH sum, no carry-out.
module adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] result
);

    assign result = data1 + data2;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle shift-and-add multiplier for mult/multu; one shared add per cycle,
// signed operands handled by magnitude multiply plus a final 64-bit negate.
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [WIDTH-1:0]  r_mcand;
    logic              r_neg;

    logic [WIDTH-1:0]  w_addend;
    logic [WIDTH-1:0]  w_sum;
    logic              w_carry;
    logic [PROD_W-1:0] w_negated;

    // Magnitude modulo 2^WIDTH: the most negative value maps onto itself as unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    endfunction

    assign w_addend = lo[0] ? r_mcand : '0;

    adder #(.WIDTH(WIDTH)) u_adder (
        .data1  (hi),
        .data2  (w_addend),
        .result (w_sum)
    );

    // The adder has no carry-out, so recover it from unsigned wrap-around.
    assign w_carry   = (w_sum < hi);
    assign w_negated = ~{hi, lo} + PROD_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mcand <= f_abs(a, sgn);
                        hi      <= '0;
                        lo      <= f_abs(b, sgn);
                        r_count <= '0;
                        r_neg   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        busy    <= 1'b1;
                        r_state <= ST_CALC;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    {hi, lo} <= {w_carry, w_sum, lo[WIDTH-1:1]};
                    r_count  <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(MUL_STEPS - 1)) begin
                        if (r_neg) begin
                            r_state <= ST_FIX;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_FIX: begin
                    {hi, lo} <= w_negated;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    r_state  <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: cycle-level behavioural model plus directed and random operations.
module tb_mul_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles elapsed since accept (0 = idle), latency of the op, pending and visible product.
    int          m_cnt  = 0;
    int          m_lat  = 33;
    logic [63:0] m_pend = '0;
    logic [63:0] m_res  = '0;

    mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] f_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        if (s) begin
            sp = longint'($signed(x)) * longint'($signed(y));
            return 64'(sp);
        end
        up = {32'd0, x} * {32'd0, y};
        return up;
    endfunction

    function automatic int f_lat(input logic s, input logic [31:0] x, input logic [31:0] y);
        return (s && (x[31] ^ y[31])) ? 34 : 33;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_lat <= 33;
            m_res <= '0;
        end else if ((m_cnt == 0 || m_cnt == m_lat) && start) begin
            m_lat  <= f_lat(sgn, a, b);
            m_pend <= f_prod(sgn, a, b);
            m_cnt  <= 1;
        end else if (m_cnt == m_lat) begin
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) m_res <= m_pend;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(busy), 64'(m_cnt != 0 && m_cnt < m_lat));
            chk("done", 64'(done), 64'(m_cnt == m_lat));
            if (m_cnt == 0 || m_cnt == m_lat) chk("hilo_hold", {hi, lo}, m_res);
        end
    end

    // Called at a negedge; start is sampled at the following rising edge.
    task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        sgn   = s;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int start_n, input int exp_lat,
                             input logic [63:0] exp_res);
        int n  = start_n;
        int nb = 0;
        while (!done && n < 80) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        chk({name, "_busy"}, 64'(nb), 64'(exp_lat - start_n));
        chk({name, "_res"}, {hi, lo}, exp_res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(1'b0, 32'd6, 32'd7);
        wait_done("u6x7", 1, 33, 64'h00000000_0000002A);
        chk("model_u6x7", m_res, 64'h00000000_0000002A);
        @(negedge clk);

        launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("carry", 1, 33, 64'hFFFFFFFE_00000001);
        chk("model_carry", m_res, 64'hFFFFFFFE_00000001);
        @(negedge clk);

        launch(1'b1, 32'hFFFFFFFD, 32'd5);
        wait_done("sneg", 1, 34, 64'hFFFFFFFF_FFFFFFF1);
        chk("model_sneg", m_res, 64'hFFFFFFFF_FFFFFFF1);
        @(negedge clk);

        launch(1'b1, 32'h80000000, 32'h80000000);
        wait_done("scorner", 1, 33, 64'h40000000_00000000);
        @(negedge clk);

        // Start pulse during CALC must be ignored.
        launch(1'b0, 32'd100, 32'd200);
        repeat (3) @(negedge clk);
        launch(1'b1, 32'hFFFFFFFF, 32'd7);
        wait_done("ignore", 5, 33, 64'h00000000_00004E20);

        // Back-to-back: start held in the DONE cycle.
        launch(1'b0, 32'd2, 32'd3);
        wait_done("b2b", 1, 33, 64'h00000000_00000006);
        @(negedge clk);

        // Asynchronous reset in the middle of a calculation.
        launch(1'b0, 32'h0000FFFF, 32'h0000FFFF);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(1'b0, 32'd9, 32'd9);
        wait_done("post_rst", 1, 33, 64'h00000000_00000051);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic        rs;
            logic [31:0] ra;
            logic [31:0] rb;
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'd0;
                default: ;
            endcase
            launch(rs, ra, rb);
            if ($urandom_range(0, 2) == 0) begin
                repeat (3) @(negedge clk);
                launch(~rs, $urandom, $urandom);
                wait_done("rnd", 5, f_lat(rs, ra, rb), f_prod(rs, ra, rb));
            end else begin
                wait_done("rnd", 1, f_lat(rs, ra, rb), f_prod(rs, ra, rb));
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
